// File: rtl/int_rf_mp.sv
// Multi-port integer register file for the expipe stage.
// NWR commit write ports and NRD combinational issue read ports, with optional
// same-cycle write-to-read forwarding. x0 always reads as zero. A dedicated
// ra (x1) output feeds fetch. A small FSM runs a sequential bulk clear on
// context flush, zeroing CLR_PER_CYC registers per cycle while writes are
// refused.
module int_rf_mp #(
  parameter int XLEN        = 64,
  parameter int NREGS       = 32,
  parameter int NRD         = 2,
  parameter int NWR         = 2,
  parameter int BYPASS      = 1,
  parameter int CLR_PER_CYC = 4,
  localparam int IDX        = $clog2(NREGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NWR-1:0]                 wr_valid_i,
  input  logic [NWR-1:0][IDX-1:0]        wr_idx_i,
  input  logic [NWR-1:0][XLEN-1:0]       wr_value_i,
  output logic                           wr_ready_o,
  input  logic [NRD-1:0][IDX-1:0]        rd_idx_i,
  output logic [NRD-1:0][XLEN-1:0]       rd_value_o,
  output logic [XLEN-1:0]                ra_value_o,
  input  logic                           clr_req_i,
  output logic                           clr_busy_o,
  output logic                           clr_done_o
);

  // Counter is wide enough to hold NREGS + CLR_PER_CYC without wrapping, so
  // the last-chunk compare and the out-of-range index filter stay exact.
  localparam int CW = $clog2(NREGS + CLR_PER_CYC) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   clr_idx [CLR_PER_CYC];
  logic            last_chunk;
  logic [NWR-1:0]  wr_acc;
  logic [XLEN-1:0] regs_q [NREGS];

  assign last_chunk = (cnt_q + CW'(CLR_PER_CYC)) >= CW'(NREGS);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: requests only matter in IDLE, DONE always returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (clr_req_i) state_d = S_CLEAR;
      S_CLEAR: if (last_chunk) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: writes only in IDLE, busy covers CLEAR and DONE
  always_comb begin
    wr_ready_o = 1'b0;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    unique case (state_q)
      S_IDLE:  wr_ready_o = 1'b1;
      S_CLEAR: clr_busy_o = 1'b1;
      S_DONE: begin
        clr_busy_o = 1'b1;
        clr_done_o = 1'b1;
      end
      default: wr_ready_o = 1'b0;
    endcase
  end

  // Clear chunk base: advances while clearing, parked at 0 otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  cnt_q <= '0;
    else if (state_q == S_CLEAR)  cnt_q <= cnt_q + CW'(CLR_PER_CYC);
    else                          cnt_q <= '0;
  end

  // Register indices covered by the current clear chunk
  always_comb begin
    for (int k = 0; k < CLR_PER_CYC; k++) begin
      clr_idx[k] = cnt_q + CW'(k);
    end
  end

  // Write acceptance: writes to x0 and writes outside IDLE are dropped
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wr_acc[p] = wr_valid_i[p] && wr_ready_o && (wr_idx_i[p] != '0);
    end
  end

  // Storage update: clear chunk or commits; ascending port loop lets the
  // highest-numbered port win on a same-index conflict
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == S_CLEAR) begin
      for (int k = 0; k < CLR_PER_CYC; k++) begin
        if ((clr_idx[k] < CW'(NREGS)) && (clr_idx[k] != '0)) begin
          regs_q[clr_idx[k][IDX-1:0]] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_acc[p]) regs_q[wr_idx_i[p]] <= wr_value_i[p];
      end
    end
  end

  // Read ports: stored value, optionally overridden by the winning same-cycle
  // write, and forced to zero for x0
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_value_o[r] = regs_q[rd_idx_i[r]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_acc[p] && (wr_idx_i[p] == rd_idx_i[r])) rd_value_o[r] = wr_value_i[p];
        end
      end
      if (rd_idx_i[r] == '0) rd_value_o[r] = '0;
    end
  end

  assign ra_value_o = regs_q[1];

endmodule

// File: tb/tb_int_rf_mp.sv
// Directed bench for int_rf_mp (BYPASS=1, 32 x 64-bit, 2R/2W, 4 clears/cycle).
// Expected values are queued while stimulus is driven and compared at the
// following falling edge.
module tb_int_rf_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int IDX   = 5;

  localparam int K_RD   = 0;
  localparam int K_RA   = 1;
  localparam int K_RDY  = 2;
  localparam int K_BUSY = 3;
  localparam int K_DONE = 4;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic [NWR-1:0]            wr_valid;
  logic [NWR-1:0][IDX-1:0]   wr_idx;
  logic [NWR-1:0][XLEN-1:0]  wr_value;
  logic                      wr_ready;
  logic [NRD-1:0][IDX-1:0]   rd_idx;
  logic [NRD-1:0][XLEN-1:0]  rd_value;
  logic [XLEN-1:0]           ra_value;
  logic                      clr_req;
  logic                      clr_busy;
  logic                      clr_done;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string           tag;
    int              kind;
    int              port;
    logic [XLEN-1:0] val;
  } exp_t;

  exp_t sb[$];

  int_rf_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .CLR_PER_CYC(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_valid_i (wr_valid),
    .wr_idx_i   (wr_idx),
    .wr_value_i (wr_value),
    .wr_ready_o (wr_ready),
    .rd_idx_i   (rd_idx),
    .rd_value_o (rd_value),
    .ra_value_o (ra_value),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [XLEN-1:0] obs(int kind, int port);
    case (kind)
      K_RD:    return rd_value[port];
      K_RA:    return ra_value;
      K_RDY:   return {{(XLEN-1){1'b0}}, wr_ready};
      K_BUSY:  return {{(XLEN-1){1'b0}}, clr_busy};
      default: return {{(XLEN-1){1'b0}}, clr_done};
    endcase
  endfunction

  task automatic exp_rd(string tag, int p, logic [XLEN-1:0] v);
    exp_t e;
    e.tag = tag; e.kind = K_RD; e.port = p; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_st(string tag, int kind, logic [XLEN-1:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.port = 0; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_ctl(string tag, logic rdy, logic busy, logic done);
    exp_st({tag, "_rdy"},  K_RDY,  {{(XLEN-1){1'b0}}, rdy});
    exp_st({tag, "_busy"}, K_BUSY, {{(XLEN-1){1'b0}}, busy});
    exp_st({tag, "_done"}, K_DONE, {{(XLEN-1){1'b0}}, done});
  endtask

  // Compare every queued expectation at the falling edge of the current cycle.
  task automatic check();
    exp_t e;
    logic [XLEN-1:0] o;
    @(negedge clk_i);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.kind, e.port);
      tests++;
      assert (o === e.val) else begin
        failed++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc();
    check();
    tick();
  endtask

  task automatic idle_in();
    wr_valid = '0;
    clr_req  = 1'b0;
  endtask

  task automatic wr(int p, int idx, logic [XLEN-1:0] v);
    wr_valid[p] = 1'b1;
    wr_idx[p]   = IDX'(idx);
    wr_value[p] = v;
  endtask

  task automatic read_all_zero(string tag);
    for (int i = 0; i < NREGS; i++) begin
      rd_idx[0] = IDX'(i);
      rd_idx[1] = IDX'(NREGS - 1 - i);
      exp_rd({tag, "_p0"}, 0, '0);
      exp_rd({tag, "_p1"}, 1, '0);
      cyc();
    end
  endtask

  initial begin
    rst_ni   = 1'b0;
    wr_valid = '0;
    wr_idx   = '0;
    wr_value = '0;
    rd_idx   = '0;
    clr_req  = 1'b0;
    tick();

    // Outputs held in reset
    exp_ctl("in_reset", 1'b1, 1'b0, 1'b0);
    exp_st("in_reset_ra", K_RA, '0);
    cyc();
    rst_ni = 1'b1;

    // 1: everything reads zero after reset
    exp_ctl("post_reset", 1'b1, 1'b0, 1'b0);
    read_all_zero("reset_rd");

    // 2: same-cycle bypass, then stored value
    wr(0, 5, 64'hDEAD);
    rd_idx[0] = 5'd5;
    rd_idx[1] = 5'd6;
    exp_rd("bypass_x5", 0, 64'hDEAD);
    exp_rd("bypass_other_idx", 1, '0);
    cyc();
    idle_in();
    exp_rd("stored_x5", 0, 64'hDEAD);
    cyc();

    // 3: same-index conflict, highest port wins (also through the bypass)
    wr(0, 7, 64'h11);
    wr(1, 7, 64'h22);
    rd_idx[1] = 5'd7;
    exp_rd("conflict_bypass_x7", 1, 64'h22);
    cyc();
    idle_in();
    wr(0, 0, 64'h55);
    rd_idx[0] = 5'd0;
    exp_rd("x0_write_bypass", 0, '0);
    exp_rd("conflict_stored_x7", 1, 64'h22);
    cyc();
    idle_in();
    exp_rd("x0_after_write", 0, '0);
    cyc();

    // Different indices commit in parallel
    wr(0, 8, 64'h88);
    wr(1, 9, 64'h99);
    cyc();
    idle_in();
    rd_idx[0] = 5'd8;
    rd_idx[1] = 5'd9;
    exp_rd("par_x8", 0, 64'h88);
    exp_rd("par_x9", 1, 64'h99);
    cyc();

    // ra port: not bypassed, updates one cycle after the write
    wr(0, 1, 64'h1234);
    exp_st("ra_same_cycle", K_RA, '0);
    cyc();
    idle_in();
    exp_st("ra_next_cycle", K_RA, 64'h1234);
    cyc();

    // 4: fill x1..x31 with idx*0x100 two per cycle
    for (int i = 1; i < NREGS; i += 2) begin
      idle_in();
      wr(0, i, 64'(i * 256));
      if (i + 1 < NREGS) wr(1, i + 1, 64'((i + 1) * 256));
      tick();
    end
    idle_in();
    rd_idx[0] = 5'd31;
    rd_idx[1] = 5'd17;
    exp_rd("fill_x31", 0, 64'h1F00);
    exp_rd("fill_x17", 1, 64'h1100);
    exp_st("fill_ra", K_RA, 64'h100);
    cyc();

    clr_req = 1'b1;
    exp_ctl("clr_req_cycle", 1'b1, 1'b0, 1'b0);
    cyc();
    clr_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      exp_ctl($sformatf("clr_c%0d", c), 1'b0, 1'b1, c == 9);
      if (c == 2) begin
        rd_idx[0] = 5'd3;
        rd_idx[1] = 5'd4;
        exp_rd("partial_x3_cleared", 0, '0);
        exp_rd("partial_x4_kept", 1, 64'h400);
      end
      if (c == 8) begin
        rd_idx[0] = 5'd31;
        exp_rd("partial_x31_kept", 0, 64'h1F00);
      end
      cyc();
    end
    exp_ctl("after_clear", 1'b1, 1'b0, 1'b0);
    exp_st("after_clear_ra", K_RA, '0);
    read_all_zero("after_clear_rd");

    // 5: held request -> one clear; write during CLEAR dropped, not bypassed
    clr_req = 1'b1;
    cyc();
    for (int c = 1; c <= 9; c++) begin
      wr_valid = '0;
      if (c == 3) begin
        wr(0, 3, 64'h99);
        rd_idx[0] = 5'd3;
        exp_rd("clr_write_no_bypass", 0, '0);
      end
      exp_ctl($sformatf("held_c%0d", c), 1'b0, 1'b1, c == 9);
      cyc();
    end
    idle_in();
    for (int c = 0; c < 3; c++) begin
      exp_ctl($sformatf("held_after%0d", c), 1'b1, 1'b0, 1'b0);
      rd_idx[0] = 5'd3;
      exp_rd("clr_write_dropped_x3", 0, '0);
      cyc();
    end

    // 6: reset asserted in clear cycle 3
    wr(0, 2, 64'h5);
    wr(1, 30, 64'hAB);
    cyc();
    idle_in();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    tick();
    tick();
    rst_ni = 1'b0;
    rd_idx[0] = 5'd2;
    rd_idx[1] = 5'd30;
    exp_ctl("mid_rst", 1'b1, 1'b0, 1'b0);
    exp_rd("mid_rst_x2", 0, '0);
    exp_rd("mid_rst_x30", 1, '0);
    cyc();
    rst_ni = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp_ctl($sformatf("post_rst%0d", c), 1'b1, 1'b0, 1'b0);
      cyc();
    end
    read_all_zero("post_rst_rd");
    wr(0, 2, 64'h1);
    cyc();
    idle_in();
    rd_idx[0] = 5'd2;
    exp_rd("post_rst_write_x2", 0, 64'h1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
